spi_flash_cmd_ctrl: RTL

SPI_FLASH_CMD_CTRL -- requirements
Module: spi_flash_cmd_ctrl

---
 rtl/spi_flash_pkg.sv | 51 +++++
 rtl/spi_flash_byte_if.sv | 38 +++
 rtl/spi_flash_cmd_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Opcode constants, FSM state encoding and opcode decode for the SPI flash command controller.
// FLASH_BUSY_POLL_EN adds the write-in-progress polling states to the encoding.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'h20;
    localparam logic [7:0] OP_BE   = 8'hD8;
    localparam logic [7:0] OP_CE   = 8'hC7;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;

    localparam logic [8:0] MAX_LEN = 9'd256;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CS_LOW   = 4'd1,
        CMD      = 4'd2,
        ADDR     = 4'd3,
        DATA     = 4'd4,
        CS_HIGH  = 4'd5,
        DONE     = 4'd8
`ifdef FLASH_BUSY_POLL_EN
        ,
        POLL_CMD = 4'd6,
        POLL_RD  = 4'd7
`endif
    } state_t;

    typedef struct packed {
        logic has_addr;
        logic is_rd;
        logic is_wr;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [7:0] op);
        op_info_t info;
        info.has_addr = (op == OP_READ) || (op == OP_PP) || (op == OP_SE) || (op == OP_BE);
        info.is_rd    = (op == OP_READ) || (op == OP_RDID) || (op == OP_RDSR);
        info.is_wr    = (op == OP_PP);
        return info;
    endfunction

    // Opcodes that leave the flash busy and must be followed by status polling.
    function automatic logic needs_poll(input logic [7:0] op);
        return (op == OP_PP) || (op == OP_SE) || (op == OP_BE) || (op == OP_CE);
    endfunction

endpackage

// File: rtl/spi_flash_byte_if.sv
// Single-byte request/ack handshake towards the SPI byte master; request rises one cycle after start.
// spi_wr_req is masked in the ack cycle so the master never sees a back-to-back request.
module spi_flash_byte_if (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_tx_byte,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rx_byte,
    output logic       spi_wr_req,
    input  logic       spi_wr_ack,
    output logic [7:0] spi_tx_data,
    input  logic [7:0] spi_rx_data
);

    logic       r_req;
    logic [7:0] r_tx;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_req <= 1'b0;
            r_tx  <= 8'h00;
        end else if (r_req && spi_wr_ack) begin
            r_req <= 1'b0;
        end else if (i_start && !r_req) begin
            r_req <= 1'b1;
            r_tx  <= i_tx_byte;
        end
    end

    assign spi_wr_req  = r_req & ~spi_wr_ack;
    assign spi_tx_data = r_tx;
    assign o_busy      = r_req;
    assign o_done      = r_req & spi_wr_ack;
    assign o_rx_byte   = spi_rx_data;

endmodule

// File: rtl/spi_flash_cmd_ctrl.sv
// SPI flash command sequencer: opcode, optional address, read/program data, CS gap, done pulse.
// FLASH_BUSY_POLL_EN adds RDSR polling after program/erase until the WIP bit clears.
module spi_flash_cmd_ctrl
    import spi_flash_pkg::*;
#(
    parameter int unsigned CS_GAP_CYCLES = 8
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        cmd_req,
    input  logic [7:0]  cmd_code,
    input  logic [23:0] cmd_addr,
    input  logic [8:0]  cmd_len,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        wr_data_req,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        rd_data_valid,
    output logic        spi_ncs,
    output logic        spi_wr_req,
    input  logic        spi_wr_ack,
    output logic [7:0]  spi_tx_data,
    input  logic [7:0]  spi_rx_data
);

    state_t      r_state;
    logic [7:0]  r_code;
    logic [23:0] r_addr;
    logic [8:0]  r_len;
    logic [8:0]  r_cnt;
    logic [15:0] r_gap;
    op_info_t    r_info;
    logic        r_busy;
    logic        r_done;
    logic        r_ncs;
    logic        r_wdreq;
    logic        r_start;
    logic [7:0]  r_tx;
`ifdef FLASH_BUSY_POLL_EN
    logic        r_poll_pend;
`endif

    logic        w_busy;
    logic        w_done;
    logic [7:0]  w_rx;
    logic        w_can_issue;
    logic        w_has_data;

    spi_flash_byte_if u_byte_if (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .i_start     (r_start),
        .i_tx_byte   (r_tx),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_rx_byte   (w_rx),
        .spi_wr_req  (spi_wr_req),
        .spi_wr_ack  (spi_wr_ack),
        .spi_tx_data (spi_tx_data),
        .spi_rx_data (spi_rx_data)
    );

    assign w_can_issue = !w_busy && !r_start;
    assign w_has_data  = (r_info.is_rd || r_info.is_wr) && (r_len != 9'd0);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_code  <= 8'h00;
            r_addr  <= 24'h0;
            r_len   <= 9'd0;
            r_cnt   <= 9'd0;
            r_gap   <= 16'd0;
            r_info  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ncs   <= 1'b1;
            r_wdreq <= 1'b0;
            r_start <= 1'b0;
            r_tx    <= 8'h00;
`ifdef FLASH_BUSY_POLL_EN
            r_poll_pend <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            r_wdreq <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: if (cmd_req) begin
                    r_code  <= cmd_code;
                    r_addr  <= cmd_addr;
                    r_len   <= (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
                    r_info  <= decode_op(cmd_code);
`ifdef FLASH_BUSY_POLL_EN
                    r_poll_pend <= needs_poll(cmd_code);
`endif
                    r_cnt   <= 9'd0;
                    r_busy  <= 1'b1;
                    r_ncs   <= 1'b0;
                    r_state <= CS_LOW;
                end
                CS_LOW: r_state <= CMD;
                CMD: begin
                    if (w_done) begin
                        r_cnt <= 9'd0;
                        if (r_info.has_addr) r_state <= ADDR;
                        else if (w_has_data) r_state <= DATA;
                        else begin r_ncs <= 1'b1; r_gap <= 16'd0; r_state <= CS_HIGH; end
                    end else if (w_can_issue) begin
                        r_start <= 1'b1;
                        r_tx    <= r_code;
                    end
                end
                ADDR: begin
                    if (w_done) begin
                        if (r_cnt == 9'd2) begin
                            r_cnt <= 9'd0;
                            if (w_has_data) r_state <= DATA;
                            else begin r_ncs <= 1'b1; r_gap <= 16'd0; r_state <= CS_HIGH; end
                        end else begin
                            r_cnt <= r_cnt + 9'd1;
                        end
                    end else if (w_can_issue) begin
                        r_start <= 1'b1;
                        case (r_cnt[1:0])
                            2'd0:    r_tx <= r_addr[23:16];
                            2'd1:    r_tx <= r_addr[15:8];
                            default: r_tx <= r_addr[7:0];
                        endcase
                    end
                end
                DATA: begin
                    if (w_done) begin
                        if (r_cnt == r_len - 9'd1) begin
                            r_cnt <= 9'd0; r_ncs <= 1'b1; r_gap <= 16'd0; r_state <= CS_HIGH;
                        end else begin
                            r_cnt <= r_cnt + 9'd1;
                        end
                    end else if (w_can_issue) begin
                        // Program bytes take an extra cycle: wr_data_req pulses, then wr_data is sent.
                        if (!r_info.is_wr) begin
                            r_start <= 1'b1; r_tx <= 8'h00;
                        end else if (r_wdreq) begin
                            r_start <= 1'b1; r_tx <= wr_data;
                        end else begin
                            r_wdreq <= 1'b1;
                        end
                    end
                end
                CS_HIGH: begin
                    if (r_gap == 16'(CS_GAP_CYCLES - 1)) begin
`ifdef FLASH_BUSY_POLL_EN
                        if (r_poll_pend) begin
                            r_poll_pend <= 1'b0; r_ncs <= 1'b0; r_state <= POLL_CMD;
                        end else
`endif
                        begin
                            r_done <= 1'b1; r_state <= DONE;
                        end
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end
`ifdef FLASH_BUSY_POLL_EN
                POLL_CMD: begin
                    if (w_done) r_state <= POLL_RD;
                    else if (w_can_issue) begin r_start <= 1'b1; r_tx <= OP_RDSR; end
                end
                POLL_RD: begin
                    if (w_done) begin
                        if (!w_rx[0]) begin r_ncs <= 1'b1; r_gap <= 16'd0; r_state <= CS_HIGH; end
                    end else if (w_can_issue) begin
                        r_start <= 1'b1; r_tx <= 8'h00;
                    end
                end
`endif
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_busy      = r_busy;
    assign cmd_done      = r_done;
    assign wr_data_req   = r_wdreq;
    assign spi_ncs       = r_ncs;
    assign rd_data_valid = (r_state == DATA) && r_info.is_rd && w_done;
    assign rd_data       = rd_data_valid ? w_rx : 8'h00;

endmodule
